mannix_rd_arb: RTL

Read-request arbiter in the memory path, downstream of the compute engines (fcc, active, cnn picture, cnn weight, pool) and upstream of the DDR read port. It accepts single-word read requests from up to five clients and serialises them onto one memory read channel with one transaction outstanding at a time. It returns read data to the requesting client. Selection is priority-class round-robin, steered by `client_priority`, with starvation promotion for low-priority clients.

---
 rtl/mannix_mem_pkg.sv | 20 ++
 rtl/mannix_rr_pick.sv | 32 +++
 rtl/mannix_rd_arb.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/mannix_mem_pkg.sv
// Shared definitions for the mannix memory-path blocks.
// Client indices, read-arbiter FSM states and defaults.
package mannix_mem_pkg;

  localparam int NUM_CLIENTS = 5;

  localparam int CL_FCC     = 0;
  localparam int CL_ACTIVE  = 1;
  localparam int CL_CNN_PIC = 2;
  localparam int CL_CNN_WGT = 3;
  localparam int CL_POOL    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } rd_arb_state_t;

endpackage

// File: rtl/mannix_rr_pick.sv
// Rotating priority encoder: first set request at or after
// i_start, wrapping modulo N.
module mannix_rr_pick #(
  parameter  int N  = 5,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_start,
  output logic          o_found,
  output logic [IW-1:0] o_idx
);

  int            w_j;
  logic [IW-1:0] w_pos;

  // Walk offsets from far to near so the nearest hit wins.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_j     = 0;
    w_pos   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_j   = (int'(i_start) + k) % N;
      w_pos = IW'(w_j);
      if (i_req[w_pos]) begin
        o_found = 1'b1;
        o_idx   = w_pos;
      end
    end
  end

endmodule

// File: rtl/mannix_rd_arb.sv
// Read-request arbiter: serialises single-word client reads
// onto one memory read channel, one transaction in flight.
module mannix_rd_arb
  import mannix_mem_pkg::*;
#(
  parameter  int NUM_CLIENTS  = mannix_mem_pkg::NUM_CLIENTS,
  parameter  int ADDR_WIDTH   = 19,
  parameter  int DATA_WIDTH   = 32,
  parameter  int STARVE_LIMIT = 64,
  localparam int IW = $clog2(NUM_CLIENTS),
  localparam int CW = $clog2(STARVE_LIMIT + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_CLIENTS-1:0]     client_priority,
  input  logic [NUM_CLIENTS-1:0]     cl_req,
  input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] cl_addr,
  output logic [NUM_CLIENTS-1:0]     cl_rvalid,
  output logic [DATA_WIDTH-1:0]      cl_rdata,
  output logic                       mem_req,
  output logic [ADDR_WIDTH-1:0]      mem_addr,
  input  logic                       mem_gnt,
  input  logic                       mem_rvalid,
  input  logic [DATA_WIDTH-1:0]      mem_rdata,
  output logic                       busy,
  output logic [IW-1:0]              gnt_id
);

  rd_arb_state_t r_state;
  rd_arb_state_t w_state_nxt;

  logic [IW-1:0]          r_last;
  logic [IW-1:0]          r_gnt_id;
  logic [ADDR_WIDTH-1:0]  r_mem_addr;
  logic [DATA_WIDTH-1:0]  r_rdata;
  logic [NUM_CLIENTS-1:0] r_rvalid;
  logic                   r_mem_req;
  logic                   r_busy;
  logic [CW-1:0]          r_cnt [NUM_CLIENTS];

  logic [NUM_CLIENTS-1:0] w_starved;
  logic [NUM_CLIENTS-1:0] w_elig;
  logic [IW-1:0]          w_start;
  logic                   w_hi_found;
  logic [IW-1:0]          w_hi_idx;
  logic                   w_any_found;
  logic [IW-1:0]          w_any_idx;
  logic [IW-1:0]          w_win;
  logic                   w_take;
  logic                   w_cap;

  assign w_elig  = cl_req & (client_priority | w_starved);
  assign w_start = (r_last == IW'(NUM_CLIENTS - 1)) ? '0
                 : r_last + 1'b1;

  mannix_rr_pick #(.N(NUM_CLIENTS)) u_pick_hi (
    .i_req   (w_elig),
    .i_start (w_start),
    .o_found (w_hi_found),
    .o_idx   (w_hi_idx)
  );

  mannix_rr_pick #(.N(NUM_CLIENTS)) u_pick_all (
    .i_req   (cl_req),
    .i_start (w_start),
    .o_found (w_any_found),
    .o_idx   (w_any_idx)
  );

  // An empty high/starved set falls back to plain round-robin.
  assign w_win  = w_hi_found ? w_hi_idx : w_any_idx;
  assign w_take = (r_state == IDLE) && w_any_found;
  assign w_cap  = mem_rvalid &&
                  (((r_state == ISSUE) && mem_gnt) ||
                   (r_state == WAIT));

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_any_found) w_state_nxt = ISSUE;
      ISSUE:   if (mem_gnt)
                 w_state_nxt = mem_rvalid ? RESP : WAIT;
      WAIT:    if (mem_rvalid) w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last     <= IW'(NUM_CLIENTS - 1);
      r_gnt_id   <= '0;
      r_mem_addr <= '0;
    end else if (w_take) begin
      r_last     <= w_win;
      r_gnt_id   <= w_win;
      r_mem_addr <= cl_addr[int'(w_win)*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (w_cap) begin
      r_rdata <= mem_rdata;
    end
  end

  // Status outputs are flopped from next state to stay glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_req <= 1'b0;
      r_busy    <= 1'b0;
      r_rvalid  <= '0;
    end else begin
      r_mem_req <= (w_state_nxt == ISSUE);
      r_busy    <= (w_state_nxt != IDLE);
      r_rvalid  <= (w_state_nxt == RESP)
                 ? (NUM_CLIENTS'(1) << r_gnt_id) : '0;
    end
  end

  for (genvar g = 0; g < NUM_CLIENTS; g++) begin : g_starve
    logic w_served;
    assign w_served = (r_state != IDLE) &&
                      (r_gnt_id == IW'(g));
    assign w_starved[g] = (r_cnt[g] == CW'(STARVE_LIMIT));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt[g] <= '0;
      end else if (!cl_req[g] ||
                   (w_take && (w_win == IW'(g)))) begin
        r_cnt[g] <= '0;
      end else if (!w_served && !w_starved[g]) begin
        r_cnt[g] <= r_cnt[g] + 1'b1;
      end
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_addr  = r_mem_addr;
  assign busy      = r_busy;
  assign gnt_id    = r_gnt_id;
  assign cl_rvalid = r_rvalid;
  assign cl_rdata  = r_rdata;

endmodule
